// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: score width, biased-zero helper, base codes, feeder states.
// No logic and no timing of its own.
package sw_pkg;

  localparam int SCORE_WIDTH = 12;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_T = 2'b10,
    BASE_C = 2'b11
  } base_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  function automatic int sw_zero(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/sw_target_feeder_if.sv
// Command, packed-word and PE0 left-edge bundle of the target feeder.
// master is the upstream source/observer; slave is the feeder itself.
interface sw_target_feeder_if #(
  parameter int LEN_WIDTH   = 16,
  parameter int WORD_WIDTH  = 32,
  parameter int SCORE_WIDTH = 12
) ();

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [LEN_WIDTH-1:0]   cmd_len;
  logic                   w_valid;
  logic                   w_ready;
  logic [WORD_WIDTH-1:0]  w_data;
  logic [1:0]             data_out;
  logic                   en_out;
  logic [SCORE_WIDTH-1:0] M_out;
  logic [SCORE_WIDTH-1:0] I_out;
  logic [SCORE_WIDTH-1:0] High_out;
  logic                   busy;
  logic                   done;
  logic                   err_underrun;

  modport master (
    output cmd_valid, cmd_len, w_valid, w_data,
    input  cmd_ready, w_ready, data_out, en_out, M_out, I_out, High_out,
           busy, done, err_underrun
  );

  modport slave (
    input  cmd_valid, cmd_len, w_valid, w_data,
    output cmd_ready, w_ready, data_out, en_out, M_out, I_out, High_out,
           busy, done, err_underrun
  );

endinterface

// File: rtl/sw_base_unpacker.sv
// Shift register plus one-entry next-word buffer; base is combinational from registered state.
// load/word_wr write only when the owner has handshaked; adv is only legal while base_valid.
module sw_base_unpacker
  import sw_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  adv,
  input  logic                  word_wr,
  input  logic [WORD_WIDTH-1:0] word,
  output logic [1:0]            base,
  output logic                  base_valid,
  output logic                  need_word,
  output logic                  nbuf_valid
);

  localparam int BPW = WORD_WIDTH / 2;
  localparam int CW  = $clog2(BPW);

  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] nbuf;
  logic [CW-1:0]         cnt;

  // cnt is the number of bases still waiting in shreg; zero means the next base comes from nbuf.
  assign need_word  = (cnt == '0);
  assign base_valid = !need_word || nbuf_valid;
  assign base       = need_word ? nbuf[1:0] : shreg[1:0];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      shreg      <= '0;
      nbuf       <= '0;
      cnt        <= '0;
      nbuf_valid <= 1'b0;
    end else begin
      if (load) begin
        shreg <= word >> 2;
        cnt   <= CW'(BPW - 1);
      end else if (adv) begin
        if (need_word) begin
          shreg <= nbuf >> 2;
          cnt   <= CW'(BPW - 1);
        end else begin
          shreg <= shreg >> 2;
          cnt   <= cnt - 1'b1;
        end
      end

      if (word_wr && !load) begin
        nbuf       <= word;
        nbuf_valid <= 1'b1;
      end else if (adv && need_word) begin
        nbuf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sw_target_feeder.sv
// Feeds PE0 one target base per cycle (first base one cycle after the first word handshake), then drains.
// w_ready only while a needed word has room; cmd_ready only in IDLE; outputs other than the readies are registered.
module sw_target_feeder
  import sw_pkg::*;
#(
  parameter int SCORE_WIDTH = sw_pkg::SCORE_WIDTH,
  parameter int WORD_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int NUM_PE      = 8,
  parameter logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(sw_zero(SCORE_WIDTH))
) (
  input logic               clk,
  input logic               rst,
  sw_target_feeder_if.slave bus
);

  localparam int BPW = WORD_WIDTH / 2;
  localparam int SH  = $clog2(BPW);
  localparam int DW  = $clog2(NUM_PE + 3);

  feeder_state_t        state;
  logic [LEN_WIDTH-1:0] bases_left;
  logic [LEN_WIDTH-1:0] words_left;
  logic [DW-1:0]        drain_cnt;
  logic [LEN_WIDTH:0]   len_round;

  logic       w_hs;
  logic       u_load;
  logic       u_adv;
  logic       u_word_wr;
  logic       u_clear;
  logic [1:0] u_base;
  logic       u_base_valid;
  logic       u_need_word;
  logic       u_nbuf_valid;

  assign len_round = {1'b0, bus.cmd_len} + (LEN_WIDTH + 1)'(BPW - 1);

  assign bus.cmd_ready = (state == IDLE) && rst;
  // A word may land in nbuf in the same cycle nbuf empties into the shift register.
  assign bus.w_ready   = rst && ((state == PRIME) ||
                                 ((state == STREAM) && (words_left != '0) &&
                                  (!u_nbuf_valid || u_need_word)));
  assign w_hs          = bus.w_valid && bus.w_ready;

  assign u_load    = (state == PRIME) && w_hs;
  assign u_word_wr = (state == STREAM) && w_hs;
  assign u_adv     = (state == STREAM) && u_base_valid;
  assign u_clear   = (state == IDLE) || (state == DRAIN);

  assign bus.M_out    = ZERO;
  assign bus.I_out    = ZERO;
  assign bus.High_out = ZERO;

  sw_base_unpacker #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_unpacker (
    .clk        (clk),
    .rst        (rst),
    .clear      (u_clear),
    .load       (u_load),
    .adv        (u_adv),
    .word_wr    (u_word_wr),
    .word       (bus.w_data),
    .base       (u_base),
    .base_valid (u_base_valid),
    .need_word  (u_need_word),
    .nbuf_valid (u_nbuf_valid)
  );

  // After the last base the drain counter starts one higher, because en_out is still high for that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      bases_left       <= '0;
      words_left       <= '0;
      drain_cnt        <= '0;
      bus.data_out     <= 2'b00;
      bus.en_out       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.err_underrun <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bases_left       <= bus.cmd_len;
            words_left       <= LEN_WIDTH'(len_round >> SH);
            bus.err_underrun <= 1'b0;
            bus.busy         <= 1'b1;
            drain_cnt        <= DW'(NUM_PE + 1);
            state            <= (bus.cmd_len == '0) ? DRAIN : PRIME;
          end
        end
        PRIME: begin
          if (w_hs) begin
            words_left   <= words_left - 1'b1;
            bases_left   <= bases_left - 1'b1;
            bus.en_out   <= 1'b1;
            bus.data_out <= bus.w_data[1:0];
            drain_cnt    <= DW'(NUM_PE + 2);
            state        <= (bases_left == LEN_WIDTH'(1)) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (w_hs) begin
            words_left <= words_left - 1'b1;
          end
          if (!u_base_valid) begin
            bus.err_underrun <= 1'b1;
            bus.en_out       <= 1'b0;
            bus.data_out     <= 2'b00;
            drain_cnt        <= DW'(NUM_PE + 1);
            state            <= DRAIN;
          end else begin
            bus.en_out   <= 1'b1;
            bus.data_out <= u_base;
            bases_left   <= bases_left - 1'b1;
            drain_cnt    <= DW'(NUM_PE + 2);
            if (bases_left == LEN_WIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          bus.en_out   <= 1'b0;
          bus.data_out <= 2'b00;
          if (drain_cnt == '0) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
